// File: rtl/monochrome_ctrl_pkg.sv
// Shared video definitions: monochrome mode encodings and the mode-apply FSM states.
package monochrome_ctrl_pkg;

    localparam logic [1:0] MODE_COLOUR = 2'b00;
    localparam logic [1:0] MODE_GREEN  = 2'b01;
    localparam logic [1:0] MODE_AMBER  = 2'b10;
    localparam logic [1:0] MODE_GREY   = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } apply_state_t;

endpackage

// File: rtl/monochrome_ctrl_button_debounce.sv
// Hotkey front end: 2-flop synchronizer, level debouncer and press (rising) pulse.
module button_debounce #(
    parameter int DBW = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press
);

    localparam logic [DBW-1:0] CNT_MAX = '1;

    logic           sync1;
    logic           sync2;
    logic           level_q;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX - 1'b1) begin
                // count reaches 2^DBW-1 on this differing cycle: accept the level
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/monochrome_ctrl.sv
// Monochrome mode controller: key/CPU mode requests, applied only on vblank rising edges.
//   state      | meaning
//   ST_IDLE    | requested mode equals applied mode
//   ST_PENDING | request waiting for the next vblank rising edge
module monochrome_ctrl
    import monochrome_ctrl_pkg::*;
#(
    parameter int         DBW          = 16,
    parameter logic [1:0] DEFAULT_MODE = MODE_COLOUR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_cycle,
    input  logic       reg_we,
    input  logic [1:0] reg_din,
    input  logic       vblank,
    output logic [1:0] monochrome_selection,
    output logic [1:0] mode_req,
    output logic       pending
);

    apply_state_t state;
    logic         key_level;
    logic         key_press;
    logic         vblank_q;
    logic         vb_rise;
    logic [1:0]   req_next;
    logic [1:0]   sel_next;

    button_debounce #(.DBW(DBW)) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_cycle),
        .level (key_level),
        .press (key_press)
    );

    assign vb_rise = vblank & ~vblank_q;

    // CPU write wins over a simultaneous key press
    always_comb begin
        req_next = mode_req;
        if (reg_we) begin
            req_next = reg_din;
        end else if (key_press) begin
            req_next = mode_req + 2'd1;
        end
    end

    // the load takes the pre-update request; a same-cycle update stays pending
    assign sel_next = (state == ST_PENDING && vb_rise) ? mode_req : monochrome_selection;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            pending              <= 1'b0;
            vblank_q             <= 1'b0;
            mode_req             <= DEFAULT_MODE;
            monochrome_selection <= DEFAULT_MODE;
        end else begin
            vblank_q             <= vblank;
            mode_req             <= req_next;
            monochrome_selection <= sel_next;
            case (state)
                ST_IDLE: begin
                    if (req_next != sel_next) begin
                        state   <= ST_PENDING;
                        pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (req_next == sel_next) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
